ctrl_relogio: RTL and testbench
===============================

CTRL_RELOGIO -- requirements
Module: ctrl_relogio

Interface
REQ-001 Parameter DIV, default 50000000, clock cycles per second tick; legal range 4..2^26, even.
REQ-002 ctrl_clock  in  1  single system clock; all state updates on rising edge.
REQ-003 ctrl_reset  in  1  synchronous, active-high reset.
REQ-004 ctrl_btn_mode  in  1  debounced, synchronized mode button, level, high = pressed.
REQ-005 ctrl_btn_inc  in  1  debounced, synchronized increment button, level, high = pressed.
REQ-006 ctrl_addminuto  in  1  minute-carry level from the seconds counter.
REQ-007 ctrl_addhora  in  1  hour-carry level from the minutes counter.
REQ-008 ctrl_en_s  out  1  seconds-counter enable pulse.
REQ-009 ctrl_en_m  out  1  minutes-counter enable pulse.
REQ-010 ctrl_en_h  out  1  hours-counter enable pulse.
REQ-011 ctrl_clr_s  out  1  seconds-counter clear pulse.
REQ-012 ctrl_blink  out  1  display-visible flag for the field being set.
REQ-013 ctrl_estado  out  2  current state: 00 RUN, 01 SET_H, 10 SET_M; 11 never driven.

Function
REQ-014 All outputs SHALL be registered; every pulse output SHALL be high for exactly one cycle per event.
REQ-015 Prescaler SHALL count 0..DIV-1 and wrap to 0; width ceil(log2(DIV)).
REQ-016 In RUN, ctrl_en_s SHALL be high in the cycle after the prescaler equals DIV-1; in SET_H/SET_M ctrl_en_s SHALL stay 0 while the prescaler keeps running.
REQ-017 Button presses SHALL be rising edges detected against a one-cycle-delayed copy; a held button SHALL produce one press only.
REQ-018 Carry inputs SHALL be rising-edge detected the same way; levels held for many cycles SHALL produce one pulse.
REQ-019 In RUN, an ctrl_addminuto edge SHALL give ctrl_en_m high in the following cycle; an ctrl_addhora edge SHALL give ctrl_en_h high in the following cycle; both edges in one cycle SHALL give both pulses together.
REQ-020 In SET_H/SET_M, carry edges SHALL be ignored (no pulse), but the edge-detect registers SHALL still update.
REQ-021 Transitions on mode press: RUN->SET_H, SET_H->SET_M, SET_M->RUN.
REQ-022 On RUN->SET_H, the prescaler SHALL be cleared to 0.
REQ-023 On SET_M->RUN, the prescaler SHALL be cleared to 0 and ctrl_clr_s SHALL pulse in the following cycle.
REQ-024 Inc press in SET_H SHALL give ctrl_en_h the next cycle; in SET_M, ctrl_en_m the next cycle; in RUN, the press SHALL be ignored.
REQ-025 Mode and inc presses in the same cycle: mode SHALL win and the inc press SHALL be discarded.
REQ-026 ctrl_blink SHALL be 1 in RUN; in SET states it SHALL be 1 while prescaler < DIV/2 and 0 otherwise, with one cycle of registration latency.
REQ-027 ctrl_estado SHALL reflect the state register directly.

Reset
REQ-028 With ctrl_reset high at a clock edge: state RUN, prescaler 0, ctrl_en_s/m/h and ctrl_clr_s 0, ctrl_blink 1, ctrl_estado 00.
REQ-029 Reset SHALL set the button delay registers to 1, so a button held through reset gives no press; carry delay registers SHALL reset to 0.
REQ-030 Reset mid-operation (any state, any prescaler value) SHALL take priority over every event in the same cycle, and no pulse SHALL be emitted in the cycle after.

Verification
REQ-031 DIV=4, release reset, idle inputs -> ctrl_en_s high at cycles 4, 8, 12 after release; other pulses 0; ctrl_blink 1.
REQ-032 RUN; ctrl_addminuto 0->1, held 10 cycles -> exactly one ctrl_en_m pulse, one cycle after the edge; ctrl_addminuto and ctrl_addhora rising together -> ctrl_en_m and ctrl_en_h in the same cycle.
REQ-033 Mode press -> ctrl_estado 01, ctrl_en_s stops, ctrl_blink toggles 1,1,0,0 (DIV=4); inc press x3 -> three ctrl_en_h pulses; mode -> 10; inc -> one ctrl_en_m; mode -> 00 plus one ctrl_clr_s pulse, next ctrl_en_s 4 cycles later.
REQ-034 SET_H; mode and inc rising in the same cycle -> ctrl_estado 10, no ctrl_en_h pulse; RUN with inc press -> no pulse.
REQ-035 Hold ctrl_btn_mode high across reset release -> state remains RUN; ctrl_reset asserted in SET_M with prescaler 2 -> next cycle ctrl_estado 00, all pulses 0, ctrl_blink 1.

Source files
------------

// File: rtl/ctrl_relogio.sv
// rtl/ctrl_relogio.sv - clock control FSM: second prescaler, run/set modes, button and carry handling
// Registered enable/clear pulses for the seconds/minutes/hours counters plus blink flag for the set field.

module ctrl_relogio #(
  parameter int DIV = 50000000
) (
  input  logic       ctrl_clock,
  input  logic       ctrl_reset,
  input  logic       ctrl_btn_mode,
  input  logic       ctrl_btn_inc,
  input  logic       ctrl_addminuto,
  input  logic       ctrl_addhora,
  output logic       ctrl_en_s,
  output logic       ctrl_en_m,
  output logic       ctrl_en_h,
  output logic       ctrl_clr_s,
  output logic       ctrl_blink,
  output logic [1:0] ctrl_estado
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] PRESC_LAST = W'(DIV - 1);
  localparam logic [W-1:0] PRESC_HALF = W'(DIV / 2);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_SET_H = 2'b01,
    ST_SET_M = 2'b10
  } state_t;

  state_t         state;
  logic [W-1:0]   presc;
  logic           mode_d;
  logic           inc_d;
  logic           min_d;
  logic           hora_d;

  logic           mode_press;
  logic           inc_press;
  logic           min_rise;
  logic           hora_rise;
  logic           presc_last;

  // A mode press in the same cycle swallows any inc press.
  always_comb begin
    mode_press = ctrl_btn_mode & ~mode_d;
    inc_press  = ctrl_btn_inc & ~inc_d & ~mode_press;
    min_rise   = ctrl_addminuto & ~min_d;
    hora_rise  = ctrl_addhora & ~hora_d;
    presc_last = (presc == PRESC_LAST);
  end

  always_ff @(posedge ctrl_clock) begin
    if (ctrl_reset) begin
      state      <= ST_RUN;
      presc      <= '0;
      mode_d     <= 1'b1;
      inc_d      <= 1'b1;
      min_d      <= 1'b0;
      hora_d     <= 1'b0;
      ctrl_en_s  <= 1'b0;
      ctrl_en_m  <= 1'b0;
      ctrl_en_h  <= 1'b0;
      ctrl_clr_s <= 1'b0;
      ctrl_blink <= 1'b1;
    end else begin
      mode_d     <= ctrl_btn_mode;
      inc_d      <= ctrl_btn_inc;
      min_d      <= ctrl_addminuto;
      hora_d     <= ctrl_addhora;

      ctrl_en_s  <= (state == ST_RUN) && presc_last;
      ctrl_en_m  <= ((state == ST_RUN) && min_rise) || ((state == ST_SET_M) && inc_press);
      ctrl_en_h  <= ((state == ST_RUN) && hora_rise) || ((state == ST_SET_H) && inc_press);
      ctrl_clr_s <= (state == ST_SET_M) && mode_press;
      ctrl_blink <= (state == ST_RUN) || (presc < PRESC_HALF);

      presc <= presc_last ? '0 : presc + 1'b1;

      // Entering and leaving set mode restarts the second so the display phase is predictable.
      if (mode_press) begin
        case (state)
          ST_RUN: begin
            state <= ST_SET_H;
            presc <= '0;
          end
          ST_SET_H: state <= ST_SET_M;
          ST_SET_M: begin
            state <= ST_RUN;
            presc <= '0;
          end
          default: begin
            state <= ST_RUN;
            presc <= '0;
          end
        endcase
      end
    end
  end

  assign ctrl_estado = state;

endmodule

// File: tb/tb_ctrl_relogio.sv
// tb/tb_ctrl_relogio.sv - self-checking bench for ctrl_relogio with behavioural model and directed scenarios

module tb_ctrl_relogio;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic       addmin = 1'b0;
  logic       addhora = 1'b0;
  logic       en_s, en_m, en_h, clr_s, blink;
  logic [1:0] estado;
  logic [4:0] outs;

  int n_tests = 0;
  int n_fail = 0;

  ctrl_relogio #(.DIV(DIV)) dut (
    .ctrl_clock     (clk),
    .ctrl_reset     (rst),
    .ctrl_btn_mode  (btn_mode),
    .ctrl_btn_inc   (btn_inc),
    .ctrl_addminuto (addmin),
    .ctrl_addhora   (addhora),
    .ctrl_en_s      (en_s),
    .ctrl_en_m      (en_m),
    .ctrl_en_h      (en_h),
    .ctrl_clr_s     (clr_s),
    .ctrl_blink     (blink),
    .ctrl_estado    (estado)
  );

  assign outs = {en_s, en_m, en_h, clr_s, blink};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: mode is a counter modulo 3, the prescaler a counter modulo DIV, presses are 0->1 changes.
  bit model_valid = 0;
  int m_st, m_pc;
  bit m_en_s, m_en_m, m_en_h, m_clr_s, m_blink;
  bit p_mode, p_inc, p_min, p_hora;

  always @(posedge clk) begin
    bit mp, ip, mr, hr;
    if (rst) begin
      m_st = 0; m_pc = 0;
      m_en_s = 0; m_en_m = 0; m_en_h = 0; m_clr_s = 0; m_blink = 1;
      p_mode = 1; p_inc = 1; p_min = 0; p_hora = 0;
      model_valid = 1;
    end else begin
      mp = btn_mode && !p_mode;
      ip = btn_inc && !p_inc && !mp;
      mr = addmin && !p_min;
      hr = addhora && !p_hora;
      m_en_s  = (m_st == 0) && (m_pc == DIV - 1);
      m_en_m  = ((m_st == 0) && mr) || ((m_st == 2) && ip);
      m_en_h  = ((m_st == 0) && hr) || ((m_st == 1) && ip);
      m_clr_s = (m_st == 2) && mp;
      m_blink = (m_st == 0) || (m_pc < DIV / 2);
      m_pc = (mp && m_st != 1) ? 0 : (m_pc + 1) % DIV;
      if (mp) m_st = (m_st + 1) % 3;
      p_mode = btn_mode; p_inc = btn_inc; p_min = addmin; p_hora = addhora;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_outs", 32'(outs), 32'({m_en_s, m_en_m, m_en_h, m_clr_s, m_blink}));
      check("model_estado", 32'(estado), 32'(m_st));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit reached;
    tick(); tick();
    rst = 0;
    check("reset_outs", 32'(outs), 32'(5'b00001));
    check("reset_estado", 32'(estado), 32'd0);

    // seconds tick every DIV cycles after release
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("run_en_s", 32'(outs), 32'({(c % 4 == 0), 4'b0001}));
    end

    // held minute carry gives one pulse; simultaneous carries pulse together
    addmin = 1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("carry_min_once", 32'(en_m), 32'(k == 1));
    end
    addmin = 0; tick();
    addmin = 1; addhora = 1; tick();
    check("carry_both", 32'({en_m, en_h}), 32'd3);
    addmin = 0; addhora = 0; tick();
    check("carry_both_off", 32'({en_m, en_h}), 32'd0);

    // set hours, set minutes, back to run
    btn_mode = 1; tick();
    check("to_set_h", 32'(estado), 32'd1);
    btn_mode = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("set_blink", 32'({en_s, blink}), 32'({1'b0, (k % 4 < 2)}));
    end
    for (int i = 0; i < 3; i++) begin
      btn_inc = 1; tick();
      check("inc_h", 32'(en_h), 32'd1);
      btn_inc = 0; tick();
      check("inc_h_off", 32'(en_h), 32'd0);
    end
    btn_mode = 1; tick();
    check("to_set_m", 32'(estado), 32'd2);
    btn_mode = 0; tick();
    btn_inc = 1; tick();
    check("inc_m", 32'({en_m, en_h}), 32'd2);
    btn_inc = 0; tick();
    btn_mode = 1; tick();
    check("to_run", 32'({estado, clr_s}), 32'({2'b00, 1'b1}));
    btn_mode = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("run_restart", 32'({en_s, clr_s}), 32'({(k == 4), 1'b0}));
    end

    // mode wins over inc; inc ignored in run
    btn_mode = 1; tick(); btn_mode = 0; tick();
    check("set_h_again", 32'(estado), 32'd1);
    btn_mode = 1; btn_inc = 1; tick();
    check("mode_wins", 32'({estado, en_h, en_m}), 32'({2'b10, 2'b00}));
    btn_mode = 0; btn_inc = 0; tick();
    btn_mode = 1; tick();
    check("back_run", 32'(estado), 32'd0);
    btn_mode = 0; tick();
    btn_inc = 1; tick();
    check("inc_in_run", 32'({en_m, en_h}), 32'd0);
    btn_inc = 0; tick();

    // mode held across reset release; reset in SET_M at prescaler 2
    btn_mode = 1; rst = 1; tick(); tick();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("held_mode_reset", 32'(estado), 32'd0);
    end
    btn_mode = 0; tick();
    for (int i = 0; i < 2; i++) begin
      btn_mode = 1; tick(); btn_mode = 0; tick();
    end
    reached = 0;
    for (int k = 0; k < 8 && !reached; k++) begin
      if (m_st == 2 && m_pc == 2) reached = 1;
      else tick();
    end
    check("reach_set_m_p2", 32'(reached), 32'd1);
    check("set_m_state", 32'(estado), 32'd2);
    btn_inc = 1; addmin = 1; btn_mode = 1; rst = 1; tick();
    check("reset_prio", 32'({estado, outs}), 32'({2'b00, 5'b00001}));
    rst = 0; btn_inc = 0; addmin = 0; btn_mode = 0; tick();
    check("after_reset", 32'({estado, outs}), 32'({2'b00, 5'b00001}));

    // randomized run against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) btn_mode = ~btn_mode;
      if ($urandom_range(0, 5) == 0) btn_inc = ~btn_inc;
      if ($urandom_range(0, 7) == 0) addmin = ~addmin;
      if ($urandom_range(0, 11) == 0) addhora = ~addhora;
      tick();
    end
    rst = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
